alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Upstream feeder and writeback stage for the 8-bit registered ALU (top_level_alu).
//  Holds an NREGS x DATA_W register file and accepts register-addressed commands
//  (func, src1, src2, dst) over a valid/ready handshake.
//  Drives the ALU's reg1/reg2/func inputs, waits out the ALU's clocked latency,
//  then writes alu_out back to rf[dst] and pulses done.
// PARAMETERS
//  DATA_W   8  operand/result width; must equal the ALU width
//  NREGS    8  register file depth
//  ADDR_W   3  register address width; NREGS <= 2**ADDR_W
//  ALU_LAT  1  ALU clock edges from operand capture to a valid alu_result; >= 1
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       high only in IDLE
//  cmd_func     in   3       ALU func code, forwarded unchanged
//  cmd_src1     in   ADDR_W  register address for ALU reg1
//  cmd_src2     in   ADDR_W  register address for ALU reg2
//  cmd_dst      in   ADDR_W  writeback register address
//  ld_en        in   1       direct register-file load strobe
//  ld_addr      in   ADDR_W  load address
//  ld_data      in   DATA_W  load data
//  alu_reg1     out  DATA_W  to ALU reg1 (registered)
//  alu_reg2     out  DATA_W  to ALU reg2 (registered)
//  alu_func     out  3       to ALU func (registered)
//  alu_result   in   DATA_W  from ALU alu_out
//  alu_carry    in   1       from ALU carry_out
//  done         out  1       one-cycle pulse after writeback
//  done_data    out  DATA_W  value written back; held until the next done
//  busy         out  1       state != IDLE
//  dbg_raddr    in   ADDR_W  debug read address
//  dbg_rdata    out  DATA_W  combinational rf[dbg_raddr]
// BEHAVIOUR
//  - Reset: all rf entries = 0; state = IDLE; every output reg = 0; cmd_ready = 1.
//    Reset is honoured in any state; an in-flight command is dropped, with no
//    writeback and no done pulse.
//  - FSM
//    IDLE:  on cmd_valid & cmd_ready, latch dst and func.
//           At the same edge, alu_reg1 <= rf[src1], alu_reg2 <= rf[src2], alu_func <= func.
//           Go to ISSUE.
//    ISSUE: one cycle with operands stable; the ALU samples them at the closing edge.
//           Go to WAIT. Load counter = ALU_LAT.
//    WAIT:  decrement the counter each edge. At the edge where counter == 1:
//           rf[dst] <= alu_result; done <= 1; done_data <= alu_result; go to IDLE.
//  - Latency (ALU_LAT=1): command accepted at edge 0, ISSUE in cycle 1, WAIT in
//    cycle 2, done high in cycle 3. Throughput is one command per 3 cycles.
//  - done is high in the IDLE cycle after writeback.
//    A new command may be accepted in that same cycle, and it reads the updated rf.
//  - alu_reg1, alu_reg2 and alu_func hold their values between commands.
//    Later changes to rf[src] do not alter issued operands.
//  - ld_en writes rf[ld_addr] <= ld_data in any state.
//    If it coincides with a writeback to the same address, the writeback wins.
//  - cmd_* are ignored while cmd_ready = 0.
//  - Arithmetic is performed by the ALU only; no width growth; results are mod 2**DATA_W.
// CONFIGURATION
//  ALU_SEQ_FLAGS_EN defined adds two outputs, carry_flag and zero_flag, reset to 0
//  and updated at the writeback edge:
//    zero_flag  <= (alu_result == 0)
//    carry_flag <= alu_carry when func == 3'b000; otherwise carry_flag holds,
//                  because the ALU carry is only meaningful for ADD.
//  Undefined: neither port exists and no flag logic is generated.
// TESTING
//  1. Reset mid-cycle, async -> all dbg_rdata = 0, cmd_ready = 1, done = 0, busy = 0.
//  2. ld r1=0x3C, r2=0x05; cmd ADD(000) r1,r2 -> r3
//     -> done in cycle 3, done_data = 0x41, rf[3] = 0x41.
//  3. ld r1=0xFF, r2=0x01; ADD -> r4 -> rf[4] = 0x00; with FLAGS_EN: carry_flag = 1, zero_flag = 1.
//  4. SUB(001) r1=0x3C, r2=0x05 -> r5 -> 0x37. Then cmd AND r5,r2 -> r6 issued in the
//     done cycle of the SUB -> rf[6] = 0x05 (read-after-write sees 0x37).
//  5. rst_n low during WAIT of ADD -> r3 -> rf[3] = 0, no done; after release, cmd_ready = 1.
//  6. ld_en r7 = 0xAA on the same edge as a writeback of 0x11 to r7 -> rf[7] = 0x11.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: register file plus command sequencer feeding a registered ALU.
// Reads two source registers, presents them to the ALU, waits out the ALU latency,
// then writes the result back to the destination register and pulses done.
// Optional build macro: ALU_SEQ_FLAGS_EN adds carry_flag/zero_flag outputs.
module alu_operand_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NREGS   = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_func,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_reg1,
    output logic [DATA_W-1:0] alu_reg2,
    output logic [2:0]        alu_func,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              done,
    output logic [DATA_W-1:0] done_data,
    output logic              busy,
`ifdef ALU_SEQ_FLAGS_EN
    output logic              carry_flag,
    output logic              zero_flag,
`endif
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int unsigned CntW = $clog2(ALU_LAT + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(ALU_LAT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]  dst_q;
    logic [DATA_W-1:0]  rf_q [NREGS];
    logic [DATA_W-1:0]  alu_reg1_q, alu_reg2_q;
    logic [2:0]         alu_func_q;
    logic               done_q;
    logic [DATA_W-1:0]  done_data_q;
    logic               accept;
    logic               wb_en;

    // Next-state logic: accept in idle, one issue cycle, then count down the ALU latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        wb_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    wb_en   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand capture on accept; alu_func_q doubles as the latched command func.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_reg1_q  <= '0;
            alu_reg2_q  <= '0;
            alu_func_q  <= '0;
            dst_q       <= '0;
            done_q      <= 1'b0;
            done_data_q <= '0;
        end else begin
            if (accept) begin
                alu_reg1_q <= rf_q[cmd_src1];
                alu_reg2_q <= rf_q[cmd_src2];
                alu_func_q <= cmd_func;
                dst_q      <= cmd_dst;
            end
            done_q <= wb_en;
            if (wb_en) begin
                done_data_q <= alu_result;
            end
        end
    end

    // Register file: direct loads, with writeback taking priority on the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q <= '{default: '0};
        end else begin
            if (ld_en) begin
                rf_q[ld_addr] <= ld_data;
            end
            if (wb_en) begin
                rf_q[dst_q] <= alu_result;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic carry_flag_q, zero_flag_q;

    // Status flags; ALU carry is only meaningful for ADD so other funcs leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
        end else if (wb_en) begin
            zero_flag_q <= (alu_result == '0);
            if (alu_func_q == 3'b000) begin
                carry_flag_q <= alu_carry;
            end
        end
    end

    assign carry_flag = carry_flag_q;
    assign zero_flag  = zero_flag_q;
`else
    logic unused_alu_carry;
    assign unused_alu_carry = alu_carry;
`endif

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign alu_reg1  = alu_reg1_q;
    assign alu_reg2  = alu_reg2_q;
    assign alu_func  = alu_func_q;
    assign done      = done_q;
    assign done_data = done_data_q;
    assign dbg_rdata = rf_q[dbg_raddr];

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer: directed cases followed by randomized commands
// checked against an architectural register-file model. Includes a registered ALU stand-in.
module tb_alu_operand_sequencer;

    localparam int NR = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_func;
    logic [2:0] cmd_src1, cmd_src2, cmd_dst;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_reg1, alu_reg2;
    logic [2:0] alu_func;
    logic [7:0] alu_result = 8'h00;
    logic       alu_carry = 1'b0;
    logic       done;
    logic [7:0] done_data;
    logic       busy;
    logic [2:0] dbg_raddr;
    logic [7:0] dbg_rdata;
`ifdef ALU_SEQ_FLAGS_EN
    logic       carry_flag, zero_flag;
`endif

    logic [7:0] model [NR];
    logic       m_carry, m_zero;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_func   (cmd_func),
        .cmd_src1   (cmd_src1),
        .cmd_src2   (cmd_src2),
        .cmd_dst    (cmd_dst),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_reg1   (alu_reg1),
        .alu_reg2   (alu_reg2),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .done       (done),
        .done_data  (done_data),
        .busy       (busy),
`ifdef ALU_SEQ_FLAGS_EN
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
`endif
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    // ALU behaviour: {carry, result}; carry only defined for ADD.
    function automatic logic [8:0] alu_ref(input logic [2:0] f, input logic [7:0] a,
                                           input logic [7:0] b);
        case (f)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {1'b0, a << 1};
            default: return {1'b0, a >> 1};
        endcase
    endfunction

    // Registered ALU stand-in with one edge of latency.
    always_ff @(posedge clk) begin
        {alu_carry, alu_result} <= alu_ref(alu_func, alu_reg1, alu_reg2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        m_carry = 1'b0;
        m_zero  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a);
        dbg_raddr = a;
        #1;
        check(tag, dbg_rdata, model[a]);
    endtask

    // Called in a low clock phase; returns in the next low phase.
    task automatic ld(input logic [2:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        model[a] = d;
        @(negedge clk);
    endtask

    // Called in a low clock phase; returns in the done cycle (low phase), so a following
    // call issues back-to-back.
    task automatic issue(input logic [2:0] f, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] d, input bit noise, input bit mid_ld,
                         input bit collide);
        logic [7:0] a, b, mid_val;
        logic [8:0] r;
        int n;
        a = model[s1];
        b = model[s2];
        r = alu_ref(f, a, b);
        mid_val = 8'($urandom);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_func = f; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d;
        @(posedge clk); #1;
        if (noise) begin
            cmd_func = 3'($urandom); cmd_src1 = 3'($urandom);
            cmd_src2 = 3'($urandom); cmd_dst = 3'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("issue_reg1", alu_reg1, a);
                check("issue_reg2", alu_reg2, b);
                check("issue_func", alu_func, f);
                check("busy_issue", busy, 1);
                check("ready_issue", cmd_ready, 0);
                if (mid_ld) begin
                    ld_en = 1'b1; ld_addr = s1; ld_data = mid_val;
                    model[s1] = mid_val;
                end
            end
            if (n == 2) begin
                ld_en = 1'b0;
                if (collide) begin
                    ld_en = 1'b1; ld_addr = d; ld_data = 8'hAA;
                end
            end
            if (n == 3) begin
                ld_en = 1'b0;
                cmd_valid = 1'b0;
            end
        end while (!done && n < 12);
        ld_en = 1'b0;
        cmd_valid = 1'b0;
        check("latency", n, 3);
        check("done_data", done_data, r[7:0]);
        check("hold_reg1", alu_reg1, a);
        check("hold_reg2", alu_reg2, b);
        model[d] = r[7:0];
        if (f == 3'b000) m_carry = r[8];
        m_zero = (r[7:0] == 8'h00);
`ifdef ALU_SEQ_FLAGS_EN
        check("carry_flag", carry_flag, m_carry);
        check("zero_flag", zero_flag, m_zero);
`endif
        rd_check("rf_dst", d);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_func = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_raddr = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: load, then asynchronous reset mid-cycle clears everything at once
        ld(3'd1, 8'h5A);
        ld(3'd6, 8'hC3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NR; i++) rd_check("reset_rf", 3'(i));
        check("reset_ready", cmd_ready, 1);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_done_data", done_data, 0);
        check("reset_reg1", alu_reg1, 0);
`ifdef ALU_SEQ_FLAGS_EN
        check("reset_carry", carry_flag, 0);
        check("reset_zero", zero_flag, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: ADD 0x3C + 0x05 -> r3
        ld(3'd1, 8'h3C);
        ld(3'd2, 8'h05);
        issue(3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
        check("t2_sum", done_data, 8'h41);

        // 3: ADD wraps to zero with carry out
        @(negedge clk);
        ld(3'd1, 8'hFF);
        ld(3'd2, 8'h01);
        issue(3'd0, 3'd1, 3'd2, 3'd4, 1'b0, 1'b0, 1'b0);
        check("t3_wrap", done_data, 8'h00);

        // 4: SUB then AND issued in the SUB's done cycle sees the new r5
        @(negedge clk);
        ld(3'd1, 8'h3C);
        ld(3'd2, 8'h05);
        issue(3'd1, 3'd1, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0);
        check("t4_sub", done_data, 8'h37);
        issue(3'd2, 3'd5, 3'd2, 3'd6, 1'b0, 1'b0, 1'b0);
        check("t4_and", done_data, 8'h05);

        // 5: reset during WAIT drops the command
        @(negedge clk);
        ld(3'd1, 8'h10);
        ld(3'd2, 8'h20);
        cmd_valid = 1'b1; cmd_func = 3'd0; cmd_src1 = 3'd1; cmd_src2 = 3'd2; cmd_dst = 3'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_wait", busy, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_busy", busy, 0);
        check("t5_ready", cmd_ready, 1);
        check("t5_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_done", done, 0);
        end
        rd_check("t5_rf3", 3'd3);
        check("t5_ready_after", cmd_ready, 1);

        // 6: load and writeback to the same register on one edge; writeback wins
        ld(3'd1, 8'h08);
        ld(3'd2, 8'h09);
        issue(3'd0, 3'd1, 3'd2, 3'd7, 1'b0, 1'b0, 1'b1);
        check("t6_rf7", dbg_rdata, 8'h11);

        // Randomized commands with busy-time noise, mid-flight loads and collisions
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) ld(3'($urandom), 8'($urandom));
            issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) issue(3'($urandom), 3'($urandom), 3'($urandom),
                                                 3'($urandom), 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        for (int i = 0; i < NR; i++) rd_check("final_rf", 3'(i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
